// File: rtl/wordle_letter_entry.sv
// rtl/wordle_letter_entry.sv - debounced enter/clear buttons and switch-to-letter decode for the wordle FSM
// Optional feature macro: WORDLE_ENTRY_FIFO_EN (2-entry output FIFO instead of a single register).
module wordle_letter_entry #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter,
    input  logic       clear_btn,
    input  logic [9:0] switch_input,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter,
    output logic       clear_pulse,
    output logic       bad_letter,
    output logic       overflow
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // bit 0 = enter, bit 1 = clear_btn; buttons are active-low so 1 means released
    logic [1:0]       btn_s1, btn_s2, btn_db, btn_db_d;
    logic [CNT_W-1:0] btn_cnt [2];
    logic [9:0]       sw_s1, sw_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1   <= 2'b11;
            btn_s2   <= 2'b11;
            btn_db   <= 2'b11;
            btn_db_d <= 2'b11;
            sw_s1    <= '0;
            sw_s2    <= '0;
            for (int i = 0; i < 2; i++) btn_cnt[i] <= '0;
        end else begin
            btn_s1   <= {clear_btn, enter};
            btn_s2   <= btn_s1;
            sw_s1    <= switch_input;
            sw_s2    <= sw_s1;
            btn_db_d <= btn_db;
            for (int i = 0; i < 2; i++) begin
                if (btn_s2[i] == btn_db[i]) begin
                    btn_cnt[i] <= '0;
                end else if (btn_cnt[i] == CNT_LAST) begin
                    btn_db[i]  <= ~btn_db[i];
                    btn_cnt[i] <= '0;
                end else begin
                    btn_cnt[i] <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [1:0] press;
    logic       enter_evt, clear_evt;
    assign press     = btn_db_d & ~btn_db;
    assign clear_evt = press[1];
    assign enter_evt = press[0] & ~press[1];

    logic [2:0] pos;
    logic [2:0] hot_cnt;
    logic       code_ok;
    logic [4:0] letter;

    always_comb begin
        pos     = '0;
        hot_cnt = '0;
        for (int i = 0; i < 7; i++) begin
            if (sw_s2[9-i]) begin
                pos     = 3'(i);
                hot_cnt = hot_cnt + 3'd1;
            end
        end
        code_ok = (hot_cnt == 3'd1);
        letter  = {2'b00, pos};
        case (sw_s2[2:0])
            3'b000: letter = {2'b00, pos};
            3'b001: letter = 5'd7 + {2'b00, pos};
            3'b010: letter = 5'd14 + {2'b00, pos};
            3'b100: begin
                letter = 5'd21 + {2'b00, pos};
                if (pos > 3'd4) code_ok = 1'b0;
            end
            default: code_ok = 1'b0;
        endcase
    end

    logic push_ok, transfer, stall;
    assign push_ok  = enter_evt & code_ok;
    assign transfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            clear_pulse <= 1'b0;
            bad_letter  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            clear_pulse <= clear_evt;
            bad_letter  <= enter_evt & ~code_ok;
            overflow    <= push_ok & stall;
        end
    end

`ifdef WORDLE_ENTRY_FIFO_EN
    logic [4:0] fifo_q [2];
    logic [1:0] fifo_cnt;
    logic       push;

    assign out_valid  = (fifo_cnt != 2'd0);
    assign out_letter = fifo_q[0];
    assign stall      = (fifo_cnt == 2'd2) & ~transfer;
    assign push       = push_ok & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_cnt  <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else if (clear_evt) begin
            fifo_cnt <= '0;
        end else begin
            case ({push, transfer})
                2'b01: begin
                    fifo_q[0] <= fifo_q[1];
                    fifo_cnt  <= fifo_cnt - 2'd1;
                end
                2'b10: begin
                    if (fifo_cnt == 2'd0) fifo_q[0] <= letter;
                    else                  fifo_q[1] <= letter;
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd2) begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= letter;
                    end else begin
                        fifo_q[0] <= letter;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign stall = out_valid & ~transfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_letter <= '0;
        end else if (clear_evt) begin
            out_valid <= 1'b0;
        end else if (push_ok & ~stall) begin
            out_valid  <= 1'b1;
            out_letter <= letter;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_wordle_letter_entry.sv
// tb/tb_wordle_letter_entry.sv - randomized self-checking bench for wordle_letter_entry
// Honours WORDLE_ENTRY_FIFO_EN to pick the expected storage depth.
module tb_wordle_letter_entry;
    localparam int D  = 4;
    localparam int HL = D + 2;
`ifdef WORDLE_ENTRY_FIFO_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enter = 1'b1;
    logic       clear_btn = 1'b1;
    logic [9:0] switch_input = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_letter;
    logic       clear_pulse, bad_letter, overflow;

    wordle_letter_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .enter(enter), .clear_btn(clear_btn),
        .switch_input(switch_input), .out_valid(out_valid), .out_ready(out_ready),
        .out_letter(out_letter), .clear_pulse(clear_pulse), .bad_letter(bad_letter),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit rand_ready = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw-sample histories (bit k = sampled k edges ago) and a letter queue.
    logic [HL-1:0] eh, ch;
    logic [9:0]    swh [HL];
    bit            m_edb, m_cdb, m_efell, m_cfell;
    bit            m_clr, m_bad, m_ovf;
    logic [4:0]    mq [$];

    function automatic bit decode(input logic [9:0] sw, output logic [4:0] l);
        int p;
        int base;
        l = '0;
        p = 0;
        if ($countones(sw[9:3]) != 1) return 1'b0;
        for (int i = 0; i < 7; i++) if (sw[9-i]) p = i;
        case (sw[2:0])
            3'b000: base = 0;
            3'b001: base = 7;
            3'b010: base = 14;
            3'b100: begin
                if (p > 4) return 1'b0;
                base = 21;
            end
            default: return 1'b0;
        endcase
        l = 5'(base + p);
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit e_ev, c_ev, ok;
        logic [4:0] l;
        if (reset) begin
            eh = '1; ch = '1;
            for (int i = 0; i < HL; i++) swh[i] = '0;
            m_edb = 1'b1; m_cdb = 1'b1; m_efell = 1'b0; m_cfell = 1'b0;
            m_clr = 1'b0; m_bad = 1'b0; m_ovf = 1'b0;
            mq.delete();
        end else begin
            e_ev = m_efell;
            c_ev = m_cfell;
            eh = {eh[HL-2:0], enter};
            ch = {ch[HL-2:0], clear_btn};
            for (int i = HL - 1; i > 0; i--) swh[i] = swh[i-1];
            swh[0] = switch_input;
            // a level flips once the last D synced samples all disagree with it
            m_efell = 1'b0;
            if (eh[D+1:2] == {D{~m_edb}}) begin m_edb = ~m_edb; m_efell = !m_edb; end
            m_cfell = 1'b0;
            if (ch[D+1:2] == {D{~m_cdb}}) begin m_cdb = ~m_cdb; m_cfell = !m_cdb; end
            m_clr = c_ev; m_bad = 1'b0; m_ovf = 1'b0;
            if (c_ev) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (e_ev) begin
                    ok = decode(swh[2], l);
                    if (!ok)                 m_bad = 1'b1;
                    else if (mq.size() < CAP) mq.push_back(l);
                    else                     m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", int'(out_valid), int'(mq.size() > 0));
            if (mq.size() > 0) check("out_letter", int'(out_letter), int'(mq[0]));
            check("clear_pulse", int'(clear_pulse), int'(m_clr));
            check("bad_letter", int'(bad_letter), int'(m_bad));
            check("overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("rst_valid", int'(out_valid), 0);
        check("rst_letter", int'(out_letter), 0);
        check("rst_pulses", int'({clear_pulse, bad_letter, overflow}), 0);
    endtask

    task automatic press(input logic [9:0] sw, input int hold, input int gap);
        switch_input = sw;
        enter = 1'b0;
        step(hold);
        enter = 1'b1;
        step(gap);
    endtask

    function automatic logic [9:0] letter_sw(input int l);
        int g, p;
        logic [2:0] gc;
        g = l / 7;
        p = l % 7;
        case (g)
            0: gc = 3'b000;
            1: gc = 3'b001;
            2: gc = 3'b010;
            default: gc = 3'b100;
        endcase
        return {7'(7'b1000000 >> p), gc};
    endfunction

    initial begin
        reset_dut();
        chk_en = 1'b1;

        // letter I: first valid edge 7 after the low level is first sampled
        switch_input = 10'b0100000001;
        enter = 1'b0;
        step(6);
        check("lat_edge6", int'(out_valid), 0);
        step(1);
        check("lat_edge7", int'(out_valid), 1);
        check("lat_letter", int'(out_letter), 8);
        step(3);
        enter = 1'b1;
        step(10);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(4);

        press(10'b1000000000, 3, 10);      // glitch
        press(10'b0000010100, 8, 10);      // V-Z group, p=5
        press(10'b1000000000, 8, 10);      // A held
        press(10'b0100000000, 8, 10);      // B: overflow or queued
        check("hold_A", int'(out_letter), 0);
        out_ready = 1'b1;
        step(3);
        out_ready = 1'b0;

        switch_input = 10'b0010000000;      // enter + clear together
        enter = 1'b0;
        clear_btn = 1'b0;
        step(10);
        enter = 1'b1;
        clear_btn = 1'b1;
        step(10);

        enter = 1'b0;                       // reset with counter at 2
        step(4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst2_letter", int'(out_letter), 0);
        step(12);
        enter = 1'b1;
        step(10);
        out_ready = 1'b1;
        step(2);

        rand_ready = 1'b1;
        for (int it = 0; it < 60; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end else if (r < 4) begin
                clear_btn = 1'b0;
                if (r == 3) enter = 1'b0;
                step($urandom_range(2, 9));
                clear_btn = 1'b1;
                enter = 1'b1;
                step($urandom_range(1, 9));
            end else if (r < 8) begin
                press(10'($urandom), $urandom_range(1, 9), $urandom_range(1, 9));
            end else begin
                press(letter_sw($urandom_range(0, 25)), $urandom_range(1, 9), $urandom_range(1, 9));
            end
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
